shifter_rr_arbiter: RTL and testbench



---
 rtl/shifter_rr_arbiter_if.sv | 25 ++
 rtl/shifter_rr_arbiter.sv | 96 +++++++++
 tb/tb_shifter_rr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/shifter_rr_arbiter_if.sv
// Request/result bundle for shifter_rr_arbiter: N_REQ valid/ready request channels plus one result channel.
interface shifter_rr_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_a;
  logic [3*N_REQ-1:0] req_amt;
  logic [N_REQ-1:0]   req_lr;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_y;
  logic [ID_W-1:0]    out_id;

  modport master (
    output req_valid, req_a, req_amt, req_lr, out_ready,
    input  req_ready, out_valid, out_y, out_id
  );

  modport slave (
    input  req_valid, req_a, req_amt, req_lr, out_ready,
    output req_ready, out_valid, out_y, out_id
  );
endinterface

// File: rtl/shifter_rr_arbiter.sv
// Round-robin share of one 8-bit rotator; result lands in a one-entry register 1 cycle after transfer.
// Backpressure: a full register with out_ready low stalls every requester (req_ready all zero).
module shifter_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  shifter_rr_arbiter_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] win;
  logic            any_vld;
  logic            can_accept;
  logic            xfer;
  logic [7:0]      y_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      win_a;
  logic [2:0]      win_amt;
  logic            win_lr;
  logic [7:0]      rot_y;

  function automatic logic [7:0] rot8(input logic [7:0] a, input logic [2:0] amt, input logic lr);
    logic [7:0] y;
    y = '0;
    // 3-bit index arithmetic wraps modulo 8, which is exactly the rotation
    for (int i = 0; i < 8; i++) begin
      y[i] = lr ? a[3'(i) + amt] : a[3'(i) - amt];
    end
    return y;
  endfunction

  // First valid request at or after ptr, wrapping modulo N_REQ
  always_comb begin
    win     = '0;
    any_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_vld && bus.req_valid[ID_W'(idx)]) begin
        any_vld = 1'b1;
        win     = ID_W'(idx);
      end
    end
  end

  assign can_accept = (state_q == EMPTY) || bus.out_ready;
  assign xfer       = rst_n && any_vld && can_accept;
  assign ptr_nxt    = (int'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[win] = 1'b1;
  end

  assign win_a   = bus.req_a[8*win +: 8];
  assign win_amt = bus.req_amt[3*win +: 3];
  assign win_lr  = bus.req_lr[win];
  assign rot_y   = rot8(win_a, win_amt, win_lr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (bus.out_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      y_q     <= 8'h00;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        ptr_q <= ptr_nxt;
        y_q   <= rot_y;
        id_q  <= win;
      end
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_y     = y_q;
  assign bus.out_id    = id_q;

endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// Directed bench for shifter_rr_arbiter with two requesters and hand-computed rotations.
module tb_shifter_rr_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shifter_rr_arbiter_if #(.N_REQ(2), .ID_W(1)) bus ();

  shifter_rr_arbiter #(.N_REQ(2), .ID_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [2:0] amt, input logic lr);
    bus.req_a[8*i +: 8]   = a;
    bus.req_amt[3*i +: 3] = amt;
    bus.req_lr[i]         = lr;
  endtask

  // Present vld, check the combinational grant, clock once, check the captured result
  task automatic xfer(input string tag, input logic [1:0] vld, input logic [1:0] erdy,
                      input logic [7:0] ey, input logic eid);
    bus.req_valid = vld;
    #1;
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(erdy));
    tick();
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_y"},   32'(bus.out_y),     32'(ey));
    chk({tag, "_id"},  32'(bus.out_id),    32'(eid));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_amt   = '0;
    bus.req_lr    = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_y",   32'(bus.out_y),     32'h00);
    chk("rst_id",  32'(bus.out_id),    32'd0);
    chk("rst_rdy", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 2'b00;
    tick();
    rst_n = 1'b1;

    // Directed rotations, alternating requesters so each grant lands on ptr
    set_req(0, 8'h81, 3'd1, 1'b1); xfer("r81", 2'b01, 2'b01, 8'hC0, 1'b0);
    set_req(1, 8'h81, 3'd1, 1'b0); xfer("l81", 2'b10, 2'b10, 8'h03, 1'b1);
    set_req(0, 8'hA5, 3'd4, 1'b0); xfer("l4",  2'b01, 2'b01, 8'h5A, 1'b0);
    set_req(1, 8'hA5, 3'd4, 1'b1); xfer("r4",  2'b10, 2'b10, 8'h5A, 1'b1);
    set_req(0, 8'h3C, 3'd0, 1'b1); xfer("a0",  2'b01, 2'b01, 8'h3C, 1'b0);
    set_req(1, 8'h01, 3'd7, 1'b0); xfer("l7",  2'b10, 2'b10, 8'h80, 1'b1);
    set_req(0, 8'h01, 3'd3, 1'b1); xfer("r3",  2'b01, 2'b01, 8'h20, 1'b0);

    // Drain with no new request: valid falls, data holds, ptr stays at 1
    bus.req_valid = 2'b00;
    #1;
    chk("drn_rdy", 32'(bus.req_ready), 32'd0);
    tick();
    chk("drn_vld", 32'(bus.out_valid), 32'd0);
    chk("drn_y",   32'(bus.out_y),     32'h20);
    chk("drn_id",  32'(bus.out_id),    32'd0);
    tick();
    chk("idl_vld", 32'(bus.out_valid), 32'd0);
    set_req(1, 8'h0F, 3'd1, 1'b1); xfer("idlptr", 2'b11, 2'b10, 8'h87, 1'b1);
    bus.req_valid = 2'b00;
    tick();

    // Fresh reset, then both requesters continuously valid
    rst_n = 1'b0;
    #1;
    chk("rst2_vld", 32'(bus.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    set_req(0, 8'h01, 3'd1, 1'b0);
    set_req(1, 8'h01, 3'd2, 1'b0);
    xfer("fair0", 2'b11, 2'b01, 8'h02, 1'b0);
    xfer("fair1", 2'b11, 2'b10, 8'h04, 1'b1);
    xfer("fair2", 2'b11, 2'b01, 8'h02, 1'b0);
    xfer("fair3", 2'b11, 2'b10, 8'h04, 1'b1);
    bus.req_valid = 2'b00;
    tick();
    chk("fdrn_vld", 32'(bus.out_valid), 32'd0);

    // Fill while EMPTY with out_ready low, then stall for 5 cycles
    bus.out_ready = 1'b0;
    set_req(0, 8'h81, 3'd1, 1'b1); xfer("bpf", 2'b01, 2'b01, 8'hC0, 1'b0);
    set_req(1, 8'h81, 3'd1, 1'b0);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rdy", 32'(bus.req_ready), 32'd0);
      tick();
      chk("bp_vld", 32'(bus.out_valid), 32'd1);
      chk("bp_y",   32'(bus.out_y),     32'hC0);
      chk("bp_id",  32'(bus.out_id),    32'd0);
    end
    bus.out_ready = 1'b1;
    xfer("bprel", 2'b11, 2'b10, 8'h03, 1'b1);

    // Lone requester 1 granted back to back
    set_req(1, 8'h12, 3'd4, 1'b1); xfer("solo0", 2'b10, 2'b10, 8'h21, 1'b1);
    set_req(1, 8'h80, 3'd1, 1'b0); xfer("solo1", 2'b10, 2'b10, 8'h01, 1'b1);
    set_req(1, 8'hF0, 3'd2, 1'b1); xfer("solo2", 2'b10, 2'b10, 8'h3C, 1'b1);
    set_req(0, 8'h0F, 3'd1, 1'b0); xfer("late0", 2'b11, 2'b01, 8'h1E, 1'b0);

    // Asynchronous reset between clock edges while FULL
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_vld", 32'(bus.out_valid), 32'd0);
    chk("mr_rdy", 32'(bus.req_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    xfer("mrpost", 2'b11, 2'b01, 8'h1E, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
